// File: rtl/usb_fs_pkg.sv
// Shared USB full-speed definitions: PID codes, transmit arbiter state encoding
// and an index-width helper used by the arbiter and its round-robin picker.
package usb_fs_pkg;

   localparam logic [3:0] PID_ACK   = 4'b0010;
   localparam logic [3:0] PID_NAK   = 4'b1010;
   localparam logic [3:0] PID_STALL = 4'b1110;
   localparam logic [3:0] PID_DATA0 = 4'b0011;
   localparam logic [3:0] PID_DATA1 = 4'b1011;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_BUSY = 1'b1
   } arb_state_t;

   // A single requester still needs a one-bit index
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/usb_fs_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// last+1 with wraparound. Shared with the rx-side endpoint scheduler.
module usb_fs_rr_pick
   import usb_fs_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = idx_width(N)
)
(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          valid,
   output logic [IW-1:0] winner
);

   logic [IW-1:0] idx_s;

   // Scan N candidates starting just after the previous winner
   always_comb begin
      valid  = 1'b0;
      winner = '0;
      idx_s  = '0;
      for (int k = 1; k <= N; k++) begin
         idx_s  = IW'((int'(last) + k) % N);
         winner = (!valid && req[idx_s]) ? idx_s : winner;
         valid  = valid | req[idx_s];
      end
   end

endmodule

// File: rtl/usb_fs_tx_arbiter.sv
// Shares the full-speed transmit serializer between NUM_REQ protocol engines:
// latches start strobes, grants round-robin, locks until packet end or watchdog.
module usb_fs_tx_arbiter
   import usb_fs_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 1024
)
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req_pkt_start,
   input  logic [4*NUM_REQ-1:0] req_pid,
   input  logic [NUM_REQ-1:0]   req_data_avail,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_data_get,
   output logic [NUM_REQ-1:0]   req_pkt_end,
   output logic [NUM_REQ-1:0]   req_dropped,
   output logic                 tx_pkt_start,
   output logic [3:0]           tx_pid,
   output logic                 tx_data_avail,
   output logic [7:0]           tx_data,
   input  logic                 tx_data_get,
   input  logic                 tx_pkt_end,
   output logic                 timeout
);

   localparam int IW = idx_width(NUM_REQ);
   localparam int WW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);

   arb_state_t         state_r;
   logic [NUM_REQ-1:0] pending_r;
   logic [3:0]         pend_pid_r [NUM_REQ];
   logic [IW-1:0]      grant_r;
   logic [IW-1:0]      last_grant_r;
   logic [WW-1:0]      wdog_r;

   logic               pick_valid_s;
   logic [IW-1:0]      pick_winner_s;
   logic [NUM_REQ-1:0] grant_clr_s;

   usb_fs_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req    (pending_r),
      .last   (last_grant_r),
      .valid  (pick_valid_s),
      .winner (pick_winner_s)
   );

   // Pending slot consumed by this cycle's grant, if any
   always_comb begin
      grant_clr_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_clr_s[i] = pick_valid_s && (state_r == ARB_IDLE) && (pick_winner_s == IW'(i));
      end
   end

   // Pending slots, grant FSM, watchdog and registered strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ARB_IDLE;
         pending_r    <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            pend_pid_r[i] <= 4'h0;
         end
         grant_r      <= '0;
         last_grant_r <= IW'(NUM_REQ - 1);
         wdog_r       <= '0;
         tx_pkt_start <= 1'b0;
         tx_pid       <= 4'h0;
         timeout      <= 1'b0;
         req_dropped  <= '0;
      end else begin
         tx_pkt_start <= 1'b0;
         timeout      <= 1'b0;
         // A slot granted this edge hands its old PID on, so a new strobe there is not a drop
         req_dropped  <= req_pkt_start & pending_r & ~grant_clr_s;
         pending_r    <= (pending_r & ~grant_clr_s) | req_pkt_start;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_pkt_start[i]) begin
               pend_pid_r[i] <= req_pid[4*i +: 4];
            end else begin
               pend_pid_r[i] <= pend_pid_r[i];
            end
         end
         case (state_r)
            ARB_IDLE: begin
               if (pick_valid_s) begin
                  grant_r      <= pick_winner_s;
                  last_grant_r <= pick_winner_s;
                  tx_pid       <= pend_pid_r[pick_winner_s];
                  tx_pkt_start <= 1'b1;
                  wdog_r       <= '0;
                  state_r      <= ARB_BUSY;
               end else begin
                  state_r      <= ARB_IDLE;
               end
            end
            ARB_BUSY: begin
               if (tx_pkt_end) begin
                  state_r <= ARB_IDLE;
               end else if (wdog_r == WDOG_LAST) begin
                  state_r <= ARB_IDLE;
                  timeout <= 1'b1;
               end else begin
                  wdog_r  <= wdog_r + 1'b1;
               end
            end
            default: begin
               state_r <= ARB_IDLE;
            end
         endcase
      end
   end

   // Serializer handshake is routed only to the granted requester while busy
   always_comb begin
      tx_data_avail = 1'b0;
      tx_data       = 8'h00;
      req_data_get  = '0;
      req_pkt_end   = '0;
      if (state_r == ARB_BUSY) begin
         tx_data_avail         = req_data_avail[grant_r];
         tx_data               = req_data[{grant_r, 3'b000} +: 8];
         req_data_get[grant_r] = tx_data_get;
         req_pkt_end[grant_r]  = tx_pkt_end;
      end else begin
         tx_data_avail = 1'b0;
         tx_data       = 8'h00;
      end
   end

endmodule
